// File: rtl/atr_run_ctrl.sv
// atr_run_ctrl: produces the rx/tx run levels for the GPIO ATR stage.
// Each direction gets a turn-on delay that also filters short glitches, a
// turn-off hold, a software force, and optional RX blanking while TX runs.
module atr_run_ctrl #(
    parameter logic [7:0]  BASE           = 8'd0,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [31:0] DEFAULT_TX_DLY = 32'd0,
    parameter logic [31:0] DEFAULT_RX_DLY = 32'd0,
    parameter logic [31:0] DEFAULT_CTRL   = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        tx_active,
    input  logic        rx_active,
    output logic        run_tx,
    output logic        run_rx,
    output logic [7:0]  status
);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON_WAIT  = 2'd1,
        ST_ON       = 2'd2,
        ST_OFF_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_TX   = BASE;
    localparam logic [7:0] ADDR_RX   = BASE + 8'd1;
    localparam logic [7:0] ADDR_CTRL = BASE + 8'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Index 0 is the TX direction, index 1 is RX.
    logic [CNT_WIDTH-1:0] on_dly_q  [2];
    logic [CNT_WIDTH-1:0] on_dly_d  [2];
    logic [CNT_WIDTH-1:0] off_dly_q [2];
    logic [CNT_WIDTH-1:0] off_dly_d [2];
    logic [2:0]           ctrl_q, ctrl_d;   // {hdx_blank, force_rx, force_tx}
    logic [1:0]           act_q, act_d;
    state_t               state_q [2];
    state_t               state_d [2];
    logic [CNT_WIDTH-1:0] cnt_q [2];
    logic [CNT_WIDTH-1:0] cnt_d [2];
    logic [1:0]           run_int;
    logic                 run_tx_q, run_tx_d;
    logic                 run_rx_q, run_rx_d;

    // Settings-bus decode: a matching strobe replaces the register next cycle.
    always_comb begin
        on_dly_d  = on_dly_q;
        off_dly_d = off_dly_q;
        ctrl_d    = ctrl_q;
        if (set_stb) begin
            if (set_addr == ADDR_TX) begin
                on_dly_d[0]  = set_data[CNT_WIDTH-1:0];
                off_dly_d[0] = set_data[16 +: CNT_WIDTH];
            end
            if (set_addr == ADDR_RX) begin
                on_dly_d[1]  = set_data[CNT_WIDTH-1:0];
                off_dly_d[1] = set_data[16 +: CNT_WIDTH];
            end
            if (set_addr == ADDR_CTRL) begin
                ctrl_d = set_data[2:0];
            end
        end
    end

    // Per-direction run FSM; delays are only sampled when the counter loads,
    // so a register write never disturbs a count already in flight.
    always_comb begin
        act_d = {rx_active, tx_active};
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            run_int[i] = (state_q[i] == ST_ON) || (state_q[i] == ST_OFF_WAIT);
            case (state_q[i])
                ST_OFF: begin
                    if (act_q[i]) begin
                        if (on_dly_q[i] == '0) begin
                            state_d[i] = ST_ON;
                        end else begin
                            state_d[i] = ST_ON_WAIT;
                            cnt_d[i]   = on_dly_q[i];
                        end
                    end
                end
                ST_ON_WAIT: begin
                    if (!act_q[i]) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                        if (cnt_q[i] == CNT_ONE) state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!act_q[i]) begin
                        if (off_dly_q[i] == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_OFF_WAIT;
                            cnt_d[i]   = off_dly_q[i];
                        end
                    end
                end
                ST_OFF_WAIT: begin
                    if (act_q[i]) begin
                        state_d[i] = ST_ON;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                        if (cnt_q[i] == CNT_ONE) state_d[i] = ST_OFF;
                    end
                end
                default: state_d[i] = ST_OFF;
            endcase
        end
    end

    // Output combine: force wins over half-duplex blanking.
    always_comb begin
        run_tx_d = run_int[0] | ctrl_q[0];
        run_rx_d = (run_int[1] & ~(ctrl_q[2] & run_int[0])) | ctrl_q[1];
    end

    // State registers with synchronous reset back to defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_dly_q[0]  <= DEFAULT_TX_DLY[CNT_WIDTH-1:0];
            off_dly_q[0] <= DEFAULT_TX_DLY[16 +: CNT_WIDTH];
            on_dly_q[1]  <= DEFAULT_RX_DLY[CNT_WIDTH-1:0];
            off_dly_q[1] <= DEFAULT_RX_DLY[16 +: CNT_WIDTH];
            ctrl_q       <= DEFAULT_CTRL[2:0];
            act_q        <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            run_tx_q     <= 1'b0;
            run_rx_q     <= 1'b0;
        end else begin
            on_dly_q  <= on_dly_d;
            off_dly_q <= off_dly_d;
            ctrl_q    <= ctrl_d;
            act_q     <= act_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            run_tx_q  <= run_tx_d;
            run_rx_q  <= run_rx_d;
        end
    end

    assign run_tx = run_tx_q;
    assign run_rx = run_rx_q;
    assign status = {run_rx_q, run_tx_q, state_q[1], 2'b00, state_q[0]};

endmodule

// File: tb/tb_atr_run_ctrl.sv
// Directed testbench for atr_run_ctrl: delays, glitch filter, hold, blanking,
// force, reset and the full-range counter.
module tb_atr_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        tx_active;
    logic        rx_active;
    logic        run_tx;
    logic        run_rx;
    logic [7:0]  status;

    int checks   = 0;
    int failures = 0;

    atr_run_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .tx_active (tx_active),
        .rx_active (rx_active),
        .run_tx    (run_tx),
        .run_rx    (run_rx),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick(1);
        set_stb  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int rise, fall, hcnt, rxseen, allhigh, t, rx_at_fall, rx_before;

        reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        tx_active = 1'b0; rx_active = 1'b0;
        tick(2);
        reset = 1'b0;
        check("reset_run_tx", run_tx, 0);
        check("reset_run_rx", run_rx, 0);
        check("reset_status", status, 0);

        // Zero delays: 10-cycle activity gives a 10-cycle run, 3 clocks late.
        tx_active = 1'b1;
        rise = -1; hcnt = 0; rxseen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (run_tx && rise < 0) rise = i;
            if (run_tx) hcnt++;
            if (run_rx) rxseen = 1;
            if (i == 10) tx_active = 1'b0;
        end
        check("zero_dly_rise", rise, 3);
        check("zero_dly_width", hcnt, 10);
        check("zero_dly_rx_quiet", rxseen, 0);

        // on=5, off=4.
        wr(8'd0, 32'h0004_0005);
        tx_active = 1'b1;
        rise = -1; fall = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (run_tx && rise < 0) rise = i;
            if (!run_tx && rise > 0 && fall < 0) fall = i;
            if (i == 10) check("status_tx_on", status, 8'h42);
            if (i == 20) tx_active = 1'b0;
        end
        check("dly_rise", rise, 8);
        check("dly_fall", fall, 27);

        // 3-cycle glitch never reaches the output.
        tx_active = 1'b1;
        tick(2);
        check("status_on_wait", status, 8'h01);
        tick(1);
        tx_active = 1'b0;
        hcnt = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (run_tx) hcnt++;
        end
        check("glitch_filtered", hcnt, 0);

        // Off hold of 10 bridges a 4-cycle dropout.
        wr(8'd0, 32'h000A_0000);
        tx_active = 1'b1;
        tick(5);
        check("hold_on", run_tx, 1);
        tx_active = 1'b0;
        allhigh = 1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (!run_tx) allhigh = 0;
        end
        tx_active = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (!run_tx) allhigh = 0;
        end
        check("hold_no_gap", allhigh, 1);
        tx_active = 1'b0;
        tick(20);
        check("hold_released", run_tx, 0);

        // Half-duplex blanking, then force_rx overrides it.
        wr(8'd0, 32'h0000_0000);
        wr(8'd2, 32'h0000_0004);
        tx_active = 1'b1; rx_active = 1'b1;
        tick(3);
        check("hdx_tx_on", run_tx, 1);
        check("hdx_rx_blank", run_rx, 0);
        tick(5);
        check("hdx_rx_blank_hold", run_rx, 0);
        tx_active = 1'b0;
        fall = -1; rx_at_fall = -1; rx_before = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 2) rx_before = int'(run_rx);
            if (!run_tx && fall < 0) begin
                fall = i;
                rx_at_fall = int'(run_rx);
            end
        end
        check("hdx_tx_fall", fall, 3);
        check("hdx_rx_before", rx_before, 0);
        check("hdx_rx_return", rx_at_fall, 1);
        tx_active = 1'b1;
        tick(4);
        check("hdx_reblank", run_rx, 0);
        wr(8'd2, 32'h0000_0006);
        check("force_rx_not_yet", run_rx, 0);
        tick(1);
        check("force_rx_on", run_rx, 1);
        check("force_rx_tx_on", run_tx, 1);
        tx_active = 1'b0; rx_active = 1'b0;
        wr(8'd2, 32'h0000_0000);
        tick(10);
        check("cleanup_tx", run_tx, 0);
        check("cleanup_rx", run_rx, 0);

        // Reset in the middle of an on-delay count.
        wr(8'd2, 32'h0000_0001);
        wr(8'd0, 32'h0000_0064);
        tx_active = 1'b1;
        tick(10);
        check("pre_reset_status", status, 8'h41);
        reset = 1'b1;
        tick(1);
        check("mid_reset_run_tx", run_tx, 0);
        check("mid_reset_status", status, 0);
        reset = 1'b0; tx_active = 1'b0;
        tick(2);
        check("reset_force_cleared", run_tx, 0);
        tx_active = 1'b1;
        rise = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (run_tx && rise < 0) rise = i;
        end
        check("reset_default_dly", rise, 3);
        tx_active = 1'b0;
        tick(10);

        // Rewriting the delay mid-count only affects the next activation.
        wr(8'd0, 32'h0000_0032);
        tx_active = 1'b1;
        tick(10);
        wr(8'd0, 32'h0000_0002);
        t = 11; rise = -1;
        for (int i = 1; i <= 80; i++) begin
            tick(1);
            t++;
            if (run_tx && rise < 0) rise = t;
        end
        check("midcount_rise", rise, 53);
        tx_active = 1'b0;
        tick(5);
        check("midcount_off", run_tx, 0);
        tx_active = 1'b1;
        rise = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (run_tx && rise < 0) rise = i;
        end
        check("new_dly_rise", rise, 5);
        tx_active = 1'b0;
        tick(5);

        // All-ones on delay counts the full range on RX.
        wr(8'd1, 32'h0000_FFFF);
        rx_active = 1'b1;
        rise = -1;
        for (int i = 1; i <= 65600; i++) begin
            tick(1);
            if (i == 1000) check("max_dly_status", status, 8'h10);
            if (run_rx) begin
                rise = i;
                break;
            end
        end
        check("max_dly_rise", rise, 65538);
        rx_active = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
